fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_ctrl.sv | 119 +++++++++++
 tb/tb_fifo_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/count/flag controller for an external dual-port RAM (port A write, port B read); FIFO_CTRL_ERR_EN adds sticky ovf/udf flags.
// Latency: pop accepted at an edge -> pop_VALID and pop_data_OUT in the following cycle; a pushed word is poppable the cycle after its write.
// Backpressure: no stalls; pushes are dropped while full_OUT=1 and pops are ignored while empty_OUT=1.
module fifo_ctrl #(
    parameter int DATA  = 16,
    parameter int ADDR  = 5,
    parameter int AFULL = 2**ADDR - 4
) (
    input  logic            clK,
    input  logic            rst_N,
    input  logic            push_WR,
    input  logic [DATA-1:0] push_data_IN,
    output logic            full_OUT,
    output logic            afull_OUT,
    input  logic            pop_RD,
    output logic [DATA-1:0] pop_data_OUT,
    output logic            pop_VALID,
    output logic            empty_OUT,
    output logic [ADDR:0]   level_OUT,
    output logic            ram_a_WR,
    output logic [ADDR-1:0] ram_a_ADDR,
    output logic [DATA-1:0] ram_a_DATA,
    output logic            ram_b_WR,
    output logic [ADDR-1:0] ram_b_ADDR,
    input  logic [DATA-1:0] ram_b_DATA
`ifdef FIFO_CTRL_ERR_EN
    ,
    input  logic            err_CLR,
    output logic            ovf_OUT,
    output logic            udf_OUT
`endif
);

    localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(2**ADDR);
    localparam logic [ADDR:0] AFULL_C = (ADDR+1)'(AFULL);

    logic [ADDR-1:0] r_wr_ptr;
    logic [ADDR-1:0] r_rd_ptr;
    logic [ADDR:0]   r_count;
    logic            r_empty;
    logic            r_full;
    logic            r_afull;
    logic            r_pop_vld;

    logic            w_push;
    logic            w_pop;
    logic [ADDR:0]   w_count_nxt;

    // rst_N gates the write strobe so the RAM is never written while reset is held.
    assign w_push = push_WR & ~r_full & rst_N;
    assign w_pop  = pop_RD & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + (ADDR+1)'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - (ADDR+1)'(1);
        end
    end

    // Flags are computed from the next count so they line up with level_OUT after each edge.
    always_ff @(posedge clK or negedge rst_N) begin
        if (!rst_N) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_empty   <= 1'b1;
            r_full    <= 1'b0;
            r_afull   <= 1'b0;
            r_pop_vld <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR'(1);
            end
            r_count   <= w_count_nxt;
            r_empty   <= (w_count_nxt == '0);
            r_full    <= (w_count_nxt == DEPTH_C);
            r_afull   <= (w_count_nxt >= AFULL_C);
            r_pop_vld <= w_pop;
        end
    end

    assign full_OUT     = r_full;
    assign afull_OUT    = r_afull;
    assign empty_OUT    = r_empty;
    assign level_OUT    = r_count;
    assign pop_VALID    = r_pop_vld;
    assign pop_data_OUT = ram_b_DATA;

    assign ram_a_WR   = w_push;
    assign ram_a_ADDR = r_wr_ptr;
    assign ram_a_DATA = push_data_IN;
    assign ram_b_WR   = 1'b0;
    assign ram_b_ADDR = r_rd_ptr;

`ifdef FIFO_CTRL_ERR_EN
    logic r_ovf;
    logic r_udf;

    // A new error event wins over a simultaneous clear.
    always_ff @(posedge clK or negedge rst_N) begin
        if (!rst_N) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (push_WR & r_full)  | (r_ovf & ~err_CLR);
            r_udf <= (pop_RD  & r_empty) | (r_udf & ~err_CLR);
        end
    end

    assign ovf_OUT = r_ovf;
    assign udf_OUT = r_udf;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: queue-based reference model plus a behavioural registered-read dual-port RAM.
module tb_fifo_ctrl;

    logic        clK;
    logic        rst_N;
    logic        push_WR;
    logic [15:0] push_data_IN;
    logic        full_OUT;
    logic        afull_OUT;
    logic        pop_RD;
    logic [15:0] pop_data_OUT;
    logic        pop_VALID;
    logic        empty_OUT;
    logic [5:0]  level_OUT;
    logic        ram_a_WR;
    logic [4:0]  ram_a_ADDR;
    logic [15:0] ram_a_DATA;
    logic        ram_b_WR;
    logic [4:0]  ram_b_ADDR;
    logic [15:0] ram_b_DATA;
`ifdef FIFO_CTRL_ERR_EN
    logic        err_CLR;
    logic        ovf_OUT;
    logic        udf_OUT;
`endif

    fifo_ctrl #(.DATA(16), .ADDR(5), .AFULL(28)) dut (
        .clK(clK), .rst_N(rst_N),
        .push_WR(push_WR), .push_data_IN(push_data_IN),
        .full_OUT(full_OUT), .afull_OUT(afull_OUT),
        .pop_RD(pop_RD), .pop_data_OUT(pop_data_OUT), .pop_VALID(pop_VALID),
        .empty_OUT(empty_OUT), .level_OUT(level_OUT),
        .ram_a_WR(ram_a_WR), .ram_a_ADDR(ram_a_ADDR), .ram_a_DATA(ram_a_DATA),
        .ram_b_WR(ram_b_WR), .ram_b_ADDR(ram_b_ADDR), .ram_b_DATA(ram_b_DATA)
`ifdef FIFO_CTRL_ERR_EN
        , .err_CLR(err_CLR), .ovf_OUT(ovf_OUT), .udf_OUT(udf_OUT)
`endif
    );

    initial clK = 1'b0;
    always #5 clK = ~clK;

    logic [15:0] mem [32];
    always @(posedge clK) begin
        if (ram_a_WR) mem[ram_a_ADDR] <= ram_a_DATA;
        ram_b_DATA <= mem[ram_b_ADDR];
    end

    // Reference model: a word queue plus pointer counters advanced by accepted transfers.
    logic [15:0] q [$];
    int          m_wr, m_rd;
    logic        exp_vld;
    logic [15:0] exp_dat;
    logic        exp_awr, obs_awr;
    logic [15:0] obs_adat, exp_adat;
    int          n_tests, n_fail;

    task automatic drive(input logic p, input logic r, input logic [15:0] d);
        bit ap, ar;
        push_WR = p; pop_RD = r; push_data_IN = d;
        @(negedge clK);
        ap = p && (q.size() < 32);
        ar = r && (q.size() > 0);
        obs_awr = ram_a_WR; exp_awr = ap;
        obs_adat = ram_a_DATA; exp_adat = d;
        @(posedge clK);
        exp_vld = ar;
        if (ar) begin exp_dat = q.pop_front(); m_rd = (m_rd + 1) % 32; end
        if (ap) begin q.push_back(d); m_wr = (m_wr + 1) % 32; end
        #1;
        push_WR = 1'b0; pop_RD = 1'b0;
    endtask

    task automatic model_reset();
        q.delete(); m_wr = 0; m_rd = 0; exp_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst_N = 1'b0; push_WR = 1'b1; pop_RD = 1'b1; push_data_IN = 16'hBEEF;
        repeat (2) @(posedge clK);
        #1;
        n_tests++; if (ram_a_WR !== 1'b0) begin n_fail++; $display("FAIL rst_awr got %b want 0", ram_a_WR); end
        push_WR = 1'b0; pop_RD = 1'b0;
        #1;
        n_tests++; if (empty_OUT !== 1'b1) begin n_fail++; $display("FAIL rst_empty got %b want 1", empty_OUT); end
        n_tests++; if (full_OUT !== 1'b0 || afull_OUT !== 1'b0) begin n_fail++; $display("FAIL rst_full got %b%b want 00", full_OUT, afull_OUT); end
        n_tests++; if (pop_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_vld got %b want 0", pop_VALID); end
        n_tests++; if (level_OUT !== 6'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", level_OUT); end
        n_tests++; if (ram_a_ADDR !== 5'd0 || ram_b_ADDR !== 5'd0) begin n_fail++; $display("FAIL rst_ptr got %0d/%0d want 0/0", ram_a_ADDR, ram_b_ADDR); end
        n_tests++; if (ram_b_WR !== 1'b0) begin n_fail++; $display("FAIL rst_bwr got %b want 0", ram_b_WR); end
        @(negedge clK); rst_N = 1'b1;
        @(posedge clK); #1;
        model_reset();
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 32; i++) begin
            drive(1'b1, 1'b0, 16'(i));
            n_tests++; if (obs_awr !== 1'b1 || obs_adat !== 16'(i)) begin n_fail++; $display("FAIL fill_awr[%0d] got %b/%h want 1/%h", i, obs_awr, obs_adat, 16'(i)); end
            n_tests++; if (level_OUT !== 6'(i)) begin n_fail++; $display("FAIL fill_level got %0d want %0d", level_OUT, i); end
            n_tests++; if (full_OUT !== (i == 32)) begin n_fail++; $display("FAIL fill_full[%0d] got %b want %b", i, full_OUT, i == 32); end
            n_tests++; if (afull_OUT !== (i >= 28)) begin n_fail++; $display("FAIL fill_afull[%0d] got %b want %b", i, afull_OUT, i >= 28); end
            n_tests++; if (empty_OUT !== 1'b0) begin n_fail++; $display("FAIL fill_empty[%0d] got %b want 0", i, empty_OUT); end
        end
        drive(1'b1, 1'b0, 16'hDEAD);
        n_tests++; if (obs_awr !== 1'b0) begin n_fail++; $display("FAIL ovf_awr got %b want 0", obs_awr); end
        n_tests++; if (level_OUT !== 6'd32 || full_OUT !== 1'b1) begin n_fail++; $display("FAIL ovf_level got %0d/%b want 32/1", level_OUT, full_OUT); end
        n_tests++; if (ram_a_ADDR !== 5'(m_wr)) begin n_fail++; $display("FAIL ovf_wptr got %0d want %0d", ram_a_ADDR, m_wr); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 32; i++) begin
            drive(1'b0, 1'b1, 16'h0);
            n_tests++; if (pop_VALID !== 1'b1) begin n_fail++; $display("FAIL drain_vld[%0d] got %b want 1", i, pop_VALID); end
            n_tests++; if (pop_data_OUT !== 16'(i)) begin n_fail++; $display("FAIL drain_data[%0d] got %h want %h", i, pop_data_OUT, 16'(i)); end
            n_tests++; if (empty_OUT !== (i == 32)) begin n_fail++; $display("FAIL drain_empty[%0d] got %b want %b", i, empty_OUT, i == 32); end
        end
        drive(1'b0, 1'b1, 16'h0);
        n_tests++; if (pop_VALID !== 1'b0) begin n_fail++; $display("FAIL udf_vld got %b want 0", pop_VALID); end
        n_tests++; if (level_OUT !== 6'd0 || ram_b_ADDR !== 5'(m_rd)) begin n_fail++; $display("FAIL udf_state got %0d/%0d want 0/%0d", level_OUT, ram_b_ADDR, m_rd); end
    endtask

    task automatic test_steady();
        int wraps;
        logic [4:0] prev;
        wraps = 0;
        repeat (3) drive(1'b1, 1'b0, 16'($urandom));
        prev = ram_a_ADDR;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 1'b1, 16'($urandom));
            n_tests++; if (level_OUT !== 6'd3) begin n_fail++; $display("FAIL steady_level[%0d] got %0d want 3", i, level_OUT); end
            n_tests++; if (pop_VALID !== 1'b1 || pop_data_OUT !== exp_dat) begin n_fail++; $display("FAIL steady_data[%0d] got %b/%h want 1/%h", i, pop_VALID, pop_data_OUT, exp_dat); end
            n_tests++; if (ram_a_ADDR !== 5'(m_wr) || ram_b_ADDR !== 5'(m_rd)) begin n_fail++; $display("FAIL steady_ptr[%0d] got %0d/%0d want %0d/%0d", i, ram_a_ADDR, ram_b_ADDR, m_wr, m_rd); end
            if (prev == 5'd31 && ram_a_ADDR == 5'd0) wraps++;
            prev = ram_a_ADDR;
        end
        n_tests++; if (wraps < 3) begin n_fail++; $display("FAIL steady_wrap got %0d want >=3", wraps); end
        while (q.size() > 0) drive(1'b0, 1'b1, 16'h0);
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 1'b1, 16'h1234);
        n_tests++; if (level_OUT !== 6'd1 || pop_VALID !== 1'b0) begin n_fail++; $display("FAIL empty_both got %0d/%b want 1/0", level_OUT, pop_VALID); end
        drive(1'b0, 1'b0, 16'h0);
        n_tests++; if (pop_VALID !== 1'b0) begin n_fail++; $display("FAIL empty_both_late got %b want 0", pop_VALID); end
        repeat (31) drive(1'b1, 1'b0, 16'($urandom));
        drive(1'b1, 1'b1, 16'h5555);
        n_tests++; if (obs_awr !== 1'b0) begin n_fail++; $display("FAIL full_both_awr got %b want 0", obs_awr); end
        n_tests++; if (level_OUT !== 6'd31 || full_OUT !== 1'b0) begin n_fail++; $display("FAIL full_both got %0d/%b want 31/0", level_OUT, full_OUT); end
        n_tests++; if (pop_VALID !== 1'b1 || pop_data_OUT !== 16'h1234) begin n_fail++; $display("FAIL full_both_data got %b/%h want 1/1234", pop_VALID, pop_data_OUT); end
        while (q.size() > 0) begin
            drive(1'b0, 1'b1, 16'h0);
            n_tests++; if (pop_data_OUT !== exp_dat) begin n_fail++; $display("FAIL full_both_drain got %h want %h", pop_data_OUT, exp_dat); end
        end
    endtask

    task automatic test_random();
        int pp, pr;
        for (int i = 0; i < 400; i++) begin
            pp = (i < 200) ? 70 : 35;
            pr = (i < 200) ? 40 : 70;
            drive(($urandom_range(0, 99) < pp), ($urandom_range(0, 99) < pr), 16'($urandom));
            n_tests++; if (obs_awr !== exp_awr || (exp_awr && obs_adat !== exp_adat)) begin n_fail++; $display("FAIL rnd_awr[%0d] got %b/%h want %b/%h", i, obs_awr, obs_adat, exp_awr, exp_adat); end
            n_tests++; if (pop_VALID !== exp_vld || (exp_vld && pop_data_OUT !== exp_dat)) begin n_fail++; $display("FAIL rnd_pop[%0d] got %b/%h want %b/%h", i, pop_VALID, pop_data_OUT, exp_vld, exp_dat); end
            n_tests++; if (level_OUT !== 6'(q.size())) begin n_fail++; $display("FAIL rnd_level[%0d] got %0d want %0d", i, level_OUT, q.size()); end
            n_tests++; if ({empty_OUT, full_OUT, afull_OUT} !== {q.size() == 0, q.size() == 32, q.size() >= 28}) begin n_fail++; $display("FAIL rnd_flags[%0d] got %b%b%b lvl %0d", i, empty_OUT, full_OUT, afull_OUT, q.size()); end
            n_tests++; if (ram_a_ADDR !== 5'(m_wr) || ram_b_ADDR !== 5'(m_rd)) begin n_fail++; $display("FAIL rnd_ptr[%0d] got %0d/%0d want %0d/%0d", i, ram_a_ADDR, ram_b_ADDR, m_wr, m_rd); end
        end
    endtask

    task automatic test_reset_mid();
        while (q.size() < 11) drive(1'b1, 1'b0, 16'($urandom));
        while (q.size() > 11) drive(1'b0, 1'b1, 16'h0);
        drive(1'b0, 1'b1, 16'h0);
        n_tests++; if (level_OUT !== 6'd10 || pop_VALID !== 1'b1) begin n_fail++; $display("FAIL mid_pre got %0d/%b want 10/1", level_OUT, pop_VALID); end
        #2 rst_N = 1'b0;
        #1;
        n_tests++; if (empty_OUT !== 1'b1 || pop_VALID !== 1'b0) begin n_fail++; $display("FAIL mid_async got %b/%b want 1/0", empty_OUT, pop_VALID); end
        n_tests++; if (level_OUT !== 6'd0) begin n_fail++; $display("FAIL mid_level got %0d want 0", level_OUT); end
        #1 rst_N = 1'b1;
        @(posedge clK); #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 16'h0);
            n_tests++; if (pop_VALID !== 1'b0 || empty_OUT !== 1'b1) begin n_fail++; $display("FAIL mid_post[%0d] got %b/%b want 0/1", i, pop_VALID, empty_OUT); end
        end
        drive(1'b1, 1'b0, 16'hAAAA);
        drive(1'b0, 1'b1, 16'h0);
        n_tests++; if (pop_VALID !== 1'b1 || pop_data_OUT !== 16'hAAAA) begin n_fail++; $display("FAIL mid_fresh got %b/%h want 1/aaaa", pop_VALID, pop_data_OUT); end
    endtask

`ifdef FIFO_CTRL_ERR_EN
    task automatic test_err();
        n_tests++; if (ovf_OUT !== 1'b0 || udf_OUT !== 1'b0) begin n_fail++; $display("FAIL err_init got %b%b want 00", ovf_OUT, udf_OUT); end
        while (q.size() < 32) drive(1'b1, 1'b0, 16'($urandom));
        n_tests++; if (ovf_OUT !== 1'b0) begin n_fail++; $display("FAIL err_noovf got %b want 0", ovf_OUT); end
        drive(1'b1, 1'b0, 16'h0);
        n_tests++; if (ovf_OUT !== 1'b1) begin n_fail++; $display("FAIL err_ovf got %b want 1", ovf_OUT); end
        while (q.size() > 0) drive(1'b0, 1'b1, 16'h0);
        drive(1'b0, 1'b1, 16'h0);
        repeat (3) drive(1'b0, 1'b0, 16'h0);
        n_tests++; if (ovf_OUT !== 1'b1 || udf_OUT !== 1'b1) begin n_fail++; $display("FAIL err_hold got %b%b want 11", ovf_OUT, udf_OUT); end
        err_CLR = 1'b1;
        drive(1'b0, 1'b1, 16'h0);
        err_CLR = 1'b0;
        n_tests++; if (ovf_OUT !== 1'b0 || udf_OUT !== 1'b1) begin n_fail++; $display("FAIL err_prio got %b%b want 01", ovf_OUT, udf_OUT); end
        err_CLR = 1'b1;
        drive(1'b0, 1'b0, 16'h0);
        err_CLR = 1'b0;
        n_tests++; if (ovf_OUT !== 1'b0 || udf_OUT !== 1'b0) begin n_fail++; $display("FAIL err_clr got %b%b want 00", ovf_OUT, udf_OUT); end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0;
        rst_N = 1'b0; push_WR = 1'b0; pop_RD = 1'b0; push_data_IN = 16'h0;
`ifdef FIFO_CTRL_ERR_EN
        err_CLR = 1'b0;
`endif
        model_reset();
        test_reset();
        test_fill();
        test_drain();
        test_steady();
        test_same_cycle();
        test_random();
        test_reset_mid();
`ifdef FIFO_CTRL_ERR_EN
        while (q.size() > 0) drive(1'b0, 1'b1, 16'h0);
        rst_N = 1'b0; #1 rst_N = 1'b1;
        @(posedge clK); #1;
        model_reset();
        test_err();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
